im_loader: RTL and testbench

Boot-time program loader for the WISC-SC15 single-cycle core. It is the writer side of the instruction-memory read path. It accepts a framed byte stream, assembles 16-bit instruction words, and writes them into instruction memory. The core is held via its `hold` input until a complete, checksum-verified image has been loaded.

---
 rtl/im_loader_pkg.sv | 30 +++
 rtl/ld_cksum.sv | 50 +++++
 rtl/im_loader.sv | 184 ++++++++++++++++++
 tb/tb_im_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// -----------------------------------------------------------------------------
// wisc_loader_pkg
// Shared definitions for the WISC-SC15 boot-time image loader: FSM state
// encoding, default frame header byte and frame-field widths.
// No ports (package).
// -----------------------------------------------------------------------------
package wisc_loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned ADDR_W = 16;

   localparam logic [BYTE_W-1:0] HDR_BYTE_DEF = 8'hA5;

   // Fixed encodings so the state register stays comparable with the legacy
   // netlist when probed.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LEN_H  = 4'd1,
      ST_LEN_L  = 4'd2,
      ST_DATA_H = 4'd3,
      ST_DATA_L = 4'd4,
      ST_WRITE  = 4'd5,
      ST_CHK    = 4'd6,
      ST_DONE   = 4'd7,
      ST_ERR    = 4'd8
   } ld_state_e;

endpackage

// File: rtl/ld_cksum.sv
// -----------------------------------------------------------------------------
// ld_cksum
// 8-bit modulo-256 frame checksum accumulator.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (clears the sum)
//   clr      in   clear the sum (frame header accepted)
//   add      in   add din to the sum
//   din      in   byte to accumulate
//   sum_zero out  1 when (sum + din) mod 256 == 0, i.e. the sum would be zero
//                 after accumulating the byte currently presented
// -----------------------------------------------------------------------------
module ld_cksum
   import wisc_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add,
   input  logic [BYTE_W-1:0] din,
   output logic              sum_zero
);

   logic [BYTE_W-1:0] sum_q;
   logic [BYTE_W-1:0] sum_d;
   logic [BYTE_W-1:0] sum_plus;

   always_comb begin
      sum_plus = sum_q + din;
      sum_d    = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (add) begin
         sum_d = sum_plus;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   // Looks ahead by one byte so the CHK decision is made in the same cycle
   // the checksum byte is accepted.
   assign sum_zero = (sum_plus == '0);

endmodule

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Boot-time program loader: parses a framed byte stream
// (HDR, LEN_H, LEN_L, N x {hi, lo}, CHK), writes the 16-bit words into
// instruction memory and holds the core until a checksum-verified image is in.
// Parameters: BASE_ADDR (first IM word address), DEPTH (max word count),
//             HDR_BYTE (frame start byte).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte (transfer = in_valid && in_ready)
//   im_wr_en   out  one-cycle IM write strobe
//   im_wr_addr out  IM word address
//   im_wr_data out  IM write word
//   cpu_hold   out  core hold, high while no valid image is present
//   done       out  last frame loaded and verified
//   err        out  last frame rejected
// All outputs are registered.
// -----------------------------------------------------------------------------
module im_loader
   import wisc_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
   parameter int unsigned       DEPTH     = 65536,
   parameter logic [BYTE_W-1:0] HDR_BYTE  = HDR_BYTE_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_wr_en,
   output logic [ADDR_W-1:0] im_wr_addr,
   output logic [WORD_W-1:0] im_wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   ld_state_e         state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0] hi_q, hi_d;

   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              accept;
   logic              ck_clr, ck_add, ck_zero;
   logic [LEN_W-1:0]  len_new;
   logic              len_bad;

   assign accept  = in_valid && in_ready_q;
   assign len_new = {len_q[LEN_W-1:8], in_data};
   assign len_bad = (len_new == '0) || ({16'd0, len_new} > DEPTH);

   ld_cksum u_cksum (
      .clk      (clk),
      .rst      (rst),
      .clr      (ck_clr),
      .add      (ck_add),
      .din      (in_data),
      .sum_zero (ck_zero)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      hi_d      = hi_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ck_clr    = 1'b0;
      ck_add    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // Non-header bytes are consumed and dropped.
            if (accept && (in_data == HDR_BYTE)) begin
               ck_clr  = 1'b1;
               state_d = ST_LEN_H;
            end
         end
         ST_LEN_H: begin
            if (accept) begin
               ck_add  = 1'b1;
               len_d   = {in_data, len_q[7:0]};
               state_d = ST_LEN_L;
            end
         end
         ST_LEN_L: begin
            if (accept) begin
               ck_add = 1'b1;
               len_d  = len_new;
               if (len_bad) begin
                  state_d = ST_ERR;
               end else begin
                  idx_d   = '0;
                  state_d = ST_DATA_H;
               end
            end
         end
         ST_DATA_H: begin
            if (accept) begin
               ck_add  = 1'b1;
               hi_d    = in_data;
               state_d = ST_DATA_L;
            end
         end
         ST_DATA_L: begin
            if (accept) begin
               ck_add    = 1'b1;
               wr_addr_d = BASE_ADDR + idx_q;
               wr_data_d = {hi_q, in_data};
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_d == len_q) ? ST_CHK : ST_DATA_H;
         end
         ST_CHK: begin
            if (accept) begin
               ck_add  = 1'b1;
               state_d = ck_zero ? ST_DONE : ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet
      // line up with the state they describe.
      in_ready_d = (state_d != ST_WRITE);
      wr_en_d    = (state_d == ST_WRITE);
      hold_d     = (state_d != ST_DONE);
      done_d     = (state_d == ST_DONE);
      err_d      = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         hi_q       <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         hi_q       <= hi_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign im_wr_en   = wr_en_q;
   assign im_wr_addr = wr_addr_q;
   assign im_wr_data = wr_data_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
// Drives the same byte stream into two loaders (BASE_ADDR 0x0000 and 0xFFFF),
// predicts IM writes into per-instance queues from the frame contents and
// checks status outputs against a table of expected frame outcomes.
// -----------------------------------------------------------------------------
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;

   logic        rdy0, wen0, hold0, done0, err0;
   logic [15:0] waddr0, wdata0;
   logic        rdy1, wen1, hold1, done1, err1;
   logic [15:0] waddr1, wdata1;

   always #5 clk = ~clk;

   im_loader #(.BASE_ADDR(16'h0000)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (rdy0),
      .im_wr_en   (wen0),
      .im_wr_addr (waddr0),
      .im_wr_data (wdata0),
      .cpu_hold   (hold0),
      .done       (done0),
      .err        (err0)
   );

   im_loader #(.BASE_ADDR(16'hFFFF)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (rdy1),
      .im_wr_en   (wen1),
      .im_wr_addr (waddr1),
      .im_wr_data (wdata1),
      .cpu_hold   (hold1),
      .done       (done1),
      .err        (err1)
   );

   int          total = 0;
   int          bad = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic        rdy_chk = 1'b0;
   logic        wr_pending = 1'b0;
   logic        rdy_s;

   typedef struct {
      logic [95:0] fr;
      int          n;
      bit          garbage;
      bit          bp;
      logic        ed;
      logic        ee;
   } vec_t;

   vec_t v[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input int i, input logic [15:0] w);
      logic [15:0] a0, a1;
      a0 = 16'h0000 + 16'(i);
      a1 = 16'hFFFF + 16'(i);
      q0.push_back({a0, w});
      q1.push_back({a1, w});
   endtask

   // One clock cycle; outputs are sampled on the falling edge.
   task automatic tick();
      logic [31:0] e;
      logic        exp_w;
      @(negedge clk);
      rdy_s      = rdy0;
      exp_w      = wr_pending;
      wr_pending = 1'b0;
      if (rdy_chk) begin
         chk("wr_en", {31'd0, wen0}, {31'd0, exp_w});
         chk("in_ready", {31'd0, rdy0}, {31'd0, ~exp_w});
      end
      if (wen0) begin
         total++;
         if (q0.size() == 0) begin
            bad++;
            $display("FAIL dut0_write: got strobe addr=%h data=%h required none", waddr0, wdata0);
         end else begin
            e = q0.pop_front();
            total--;
            chk("dut0_write", {waddr0, wdata0}, e);
         end
      end
      if (wen1) begin
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL dut1_write: got strobe addr=%h data=%h required none", waddr1, wdata1);
         end else begin
            e = q1.pop_front();
            total--;
            chk("dut1_write", {waddr1, wdata1}, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit low, input bit bp);
      bit acc;
      if (bp) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      in_data  = b;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 16 && !acc; i++) begin
         tick();
         acc = rdy_s;
      end
      in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no in_ready for byte %h required acceptance", b);
      end
      wr_pending = low;
   endtask

   task automatic send_frame(input logic [95:0] fr, input int n, input bit bp);
      logic [95:0] f;
      logic [15:0] nw;
      logic [7:0]  b;
      bit          low;
      f  = fr;
      nw = {f[87:80], f[79:72]};
      for (int i = 0; i < int'(nw); i++) begin
         push_word(i, {f[95-8*(3+2*i) -: 8], f[95-8*(4+2*i) -: 8]});
      end
      for (int k = 0; k < n; k++) begin
         b   = f[95-8*k -: 8];
         low = (k >= 4) && (k < 3 + 2*int'(nw)) && (((k - 3) % 2) == 1);
         send_byte(b, low, bp);
      end
   endtask

   task automatic check_status(input string tag, input logic ed, input logic ee);
      chk({tag, "_done"}, {31'd0, done0}, {31'd0, ed});
      chk({tag, "_err"},  {31'd0, err0},  {31'd0, ee});
      chk({tag, "_hold"}, {31'd0, hold0}, {31'd0, ~ed});
      chk({tag, "_done1"}, {31'd0, done1}, {31'd0, ed});
      chk({tag, "_q0_empty"}, q0.size(), 0);
      chk({tag, "_q1_empty"}, q1.size(), 0);
   endtask

   initial begin
      v[0] = '{96'hA5_00_02_12_34_AB_CD_40_00_00_00_00,  8, 1'b0, 1'b0, 1'b1, 1'b0};
      v[1] = '{96'hA5_00_02_12_34_AB_CD_41_00_00_00_00,  8, 1'b0, 1'b0, 1'b0, 1'b1};
      v[2] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00,  3, 1'b0, 1'b0, 1'b0, 1'b1};
      v[3] = '{96'hA5_00_02_12_34_AB_CD_40_00_00_00_00,  8, 1'b0, 1'b0, 1'b1, 1'b0};
      v[4] = '{96'hA5_00_02_12_34_AB_CD_40_00_00_00_00,  8, 1'b1, 1'b1, 1'b1, 1'b0};
      v[5] = '{96'hA5_00_03_01_02_03_04_05_06_E8_00_00, 10, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset values while rst is low.
      repeat (2) tick();
      chk("rst_in_ready", {31'd0, rdy0}, 32'd0);
      chk("rst_wr_en",    {31'd0, wen0}, 32'd0);
      chk("rst_addr",     {16'd0, waddr0}, 32'd0);
      chk("rst_data",     {16'd0, wdata0}, 32'd0);
      chk("rst_addr1",    {16'd0, waddr1}, 32'd0);
      chk("rst_hold",     {31'd0, hold0}, 32'd1);
      chk("rst_done",     {31'd0, done0}, 32'd0);
      chk("rst_err",      {31'd0, err0}, 32'd0);
      rst = 1'b1;
      tick();
      chk("rel_in_ready", {31'd0, rdy0}, 32'd1);
      rdy_chk = 1'b1;

      // Frame table.
      for (int t = 0; t < 6; t++) begin
         if (v[t].garbage) begin
            send_byte(8'h00, 1'b0, 1'b1);
            send_byte(8'hFF, 1'b0, 1'b1);
         end
         send_frame(v[t].fr, v[t].n, v[t].bp);
         check_status($sformatf("vec%0d", t), v[t].ed, v[t].ee);
      end

      // Reload from DONE: header alone drops done and reasserts hold.
      send_byte(8'hA5, 1'b0, 1'b0);
      chk("reload_hold", {31'd0, hold0}, 32'd1);
      chk("reload_done", {31'd0, done0}, 32'd0);
      push_word(0, 16'h1234);
      push_word(1, 16'hABCD);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'h34, 1'b1, 1'b0);
      send_byte(8'hAB, 1'b0, 1'b0);
      send_byte(8'hCD, 1'b1, 1'b0);
      send_byte(8'h40, 1'b0, 1'b0);
      check_status("reload", 1'b1, 1'b0);

      // Reset after the first word write aborts the frame.
      push_word(0, 16'h1234);
      send_byte(8'hA5, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'h34, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      rdy_chk = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, rdy0}, 32'd0);
      chk("mid_rst_wr_en",    {31'd0, wen0}, 32'd0);
      chk("mid_rst_addr",     {16'd0, waddr0}, 32'd0);
      chk("mid_rst_data",     {16'd0, wdata0}, 32'd0);
      chk("mid_rst_hold",     {31'd0, hold0}, 32'd1);
      chk("mid_rst_done",     {31'd0, done0}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("mid_rel_in_ready", {31'd0, rdy0}, 32'd1);
      rdy_chk = 1'b1;
      send_byte(8'hAB, 1'b0, 1'b0);
      send_byte(8'hCD, 1'b0, 1'b0);
      send_byte(8'h40, 1'b0, 1'b0);
      repeat (3) tick();
      check_status("mid_rst", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
